occupancy_ctrl: RTL and testbench

Sequencing controller for the occupancy-grid datapath. It accepts cell-update requests (x, y, free/occupied) through a valid/ready handshake and buffers them in a small FIFO. It drives the datapath control lines to perform one read-modify-write per update, and it runs the full-map clear sweep on command. It sits between the scan-to-grid update logic and the occupancy datapath, and it is the only block that drives that datapath's control inputs.

---
 rtl/occupancy_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_occupancy_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/occupancy_ctrl.sv
// rtl/occupancy_ctrl.sv - occupancy-grid update/clear sequencer; OCC_CTRL_STATS_EN adds update_count
module occupancy_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_start,
    input  logic               update_valid,
    output logic               update_ready,
    input  logic [X_WIDTH-1:0] update_x,
    input  logic [Y_WIDTH-1:0] update_y,
    input  logic               update_free,
    output logic               busy,
    output logic               clear_done,
    input  logic               count_done,
    output logic               zero_cell,
    output logic               write_enable,
    output logic               cell_is_free,
    output logic               reset_counter,
    output logic               enable_counter,
    output logic [X_WIDTH-1:0] x,
`ifdef OCC_CTRL_STATS_EN
    output logic [Y_WIDTH-1:0] y,
    output logic [15:0]        update_count
`else
    output logic [Y_WIDTH-1:0] y
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = X_WIDTH + Y_WIDTH + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_UPD_READ  = 3'd1;
    localparam logic [2:0] S_UPD_WRITE = 3'd2;
    localparam logic [2:0] S_CLR_INIT  = 3'd3;
    localparam logic [2:0] S_CLR_RUN   = 3'd4;

    logic [2:0]         state;
    logic [2:0]         next_state;
    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        level;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               flush;
    logic               clear_pending;
    logic               clearing;
    logic [X_WIDTH-1:0] cur_x;
    logic [Y_WIDTH-1:0] cur_y;
    logic               cur_free;

    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign clearing = (state == S_CLR_INIT) || (state == S_CLR_RUN);

    // Reset is folded in so nothing is accepted while the block is held in reset.
    assign update_ready = !reset && !full && !clear_pending && !clearing;
    assign push         = update_valid && update_ready;
    assign busy         = (state != S_IDLE) || !empty || clear_pending;

    // Next-state selection plus the FIFO pop/flush strobes that go with each transition.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear_pending) begin
                    flush      = 1'b1;
                    next_state = S_CLR_INIT;
                end else if (!empty) begin
                    pop        = 1'b1;
                    next_state = S_UPD_READ;
                end
            end
            S_UPD_READ: next_state = S_UPD_WRITE;
            S_UPD_WRITE: begin
                if (clear_pending) begin
                    next_state = S_IDLE;
                end else if (!empty) begin
                    pop        = 1'b1;
                    next_state = S_UPD_READ;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_CLR_INIT: next_state = S_CLR_RUN;
            S_CLR_RUN: begin
                if (count_done) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {update_x, update_y, update_free};
        end
    end

    // FIFO pointers and occupancy; a flush discards whatever was queued before a clear.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Holding registers for the update currently in its read/write pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_x    <= '0;
            cur_y    <= '0;
            cur_free <= 1'b0;
        end else if (pop) begin
            {cur_x, cur_y, cur_free} <= mem[rd_ptr];
        end
    end

    // A new request wins over the clear-on-entry so a request landing that cycle is not lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            clear_pending <= 1'b0;
        end else if (clear_start) begin
            clear_pending <= 1'b1;
        end else if (state == S_IDLE) begin
            clear_pending <= 1'b0;
        end
    end

    // clear_done lands on the first IDLE cycle after the last sweep write.
    always_ff @(posedge clock) begin
        if (reset) begin
            clear_done <= 1'b0;
        end else begin
            clear_done <= (state == S_CLR_RUN) && count_done;
        end
    end

    // Datapath control decode; x/y stay 0 outside the update states.
    always_comb begin
        zero_cell      = 1'b0;
        write_enable   = 1'b0;
        cell_is_free   = 1'b0;
        reset_counter  = 1'b0;
        enable_counter = 1'b0;
        x              = '0;
        y              = '0;
        case (state)
            S_UPD_READ: begin
                x = cur_x;
                y = cur_y;
            end
            S_UPD_WRITE: begin
                x            = cur_x;
                y            = cur_y;
                cell_is_free = cur_free;
                write_enable = 1'b1;
            end
            S_CLR_INIT: reset_counter = 1'b1;
            S_CLR_RUN: begin
                zero_cell      = 1'b1;
                write_enable   = 1'b1;
                enable_counter = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef OCC_CTRL_STATS_EN
    // Saturating count of update writes, restarted by each clear.
    always_ff @(posedge clock) begin
        if (reset || ((state == S_IDLE) && clear_pending)) begin
            update_count <= '0;
        end else if ((state == S_UPD_WRITE) && (update_count != 16'hFFFF)) begin
            update_count <= update_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_occupancy_ctrl.sv
// tb/tb_occupancy_ctrl.sv - randomized self-checking bench for occupancy_ctrl
module tb_occupancy_ctrl;

    localparam int XW = 8;
    localparam int YW = 7;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear_start = 1'b0;
    logic          update_valid = 1'b0;
    logic          update_free = 1'b0;
    logic [XW-1:0] update_x = '0;
    logic [YW-1:0] update_y = '0;
    logic          count_done;
    logic          update_ready, busy, clear_done;
    logic          zero_cell, write_enable, cell_is_free, reset_counter, enable_counter;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
`ifdef OCC_CTRL_STATS_EN
    logic [15:0]   update_count;
`endif

    occupancy_ctrl #(.FIFO_DEPTH(4), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
        .clock(clock), .reset(reset), .clear_start(clear_start),
        .update_valid(update_valid), .update_ready(update_ready),
        .update_x(update_x), .update_y(update_y), .update_free(update_free),
        .busy(busy), .clear_done(clear_done), .count_done(count_done),
        .zero_cell(zero_cell), .write_enable(write_enable), .cell_is_free(cell_is_free),
        .reset_counter(reset_counter), .enable_counter(enable_counter),
`ifdef OCC_CTRL_STATS_EN
        .update_count(update_count),
`endif
        .x(x), .y(y)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Datapath stub: sweep counter with a settable length.
    int sweep_len = 32768;
    int dp_cnt = 0;
    always @(posedge clock) begin
        if (reset_counter) dp_cnt <= 0;
        else if (enable_counter) dp_cnt <= dp_cnt + 1;
    end
    assign count_done = enable_counter && (dp_cnt == sweep_len - 1);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: accepted updates must be written in order, each 2 cycles after
    // acceptance at the earliest; a clear discards whatever has not started.
    typedef struct {
        logic [XW-1:0] ux;
        logic [YW-1:0] uy;
        logic          uf;
        int            edge_n;
    } upd_t;
    upd_t expq[$];
    int wr_cyc[$];
    int accepted = 0, written = 0, discarded = 0, clears = 0, dones = 0;
    int clr_cycles = 0, last_zero_cyc = 0, done_gap = 0, last_latency = 0;
    int ready_viol = 0, xy_viol = 0;

    always @(negedge clock) begin : monitor
        upd_t e;
        if (reset) begin
            expq.delete();
            clr_cycles = 0;
        end else begin
            if (write_enable && !zero_cell) begin
                if (expq.size() == 0) begin
                    check("spurious_write", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("write_cell", {x, y, cell_is_free}, {e.ux, e.uy, e.uf});
                    last_latency = cyc - e.edge_n;
                    written++;
                    wr_cyc.push_back(cyc);
                end
            end
            if (update_valid && update_ready) begin
                e.ux = update_x; e.uy = update_y; e.uf = update_free; e.edge_n = cyc + 1;
                expq.push_back(e);
                accepted++;
            end
            if (reset_counter) begin
                discarded += expq.size();
                expq.delete();
                clears++;
                clr_cycles = 0;
            end
            if (zero_cell) begin
                clr_cycles++;
                last_zero_cyc = cyc;
                if (x != '0 || y != '0) xy_viol++;
            end
            if ((zero_cell || reset_counter) && update_ready) ready_viol++;
            if (clear_done) begin
                dones++;
                done_gap = cyc - last_zero_cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [XW-1:0] ax, input logic [YW-1:0] ay, input logic af,
                        output bit stalled);
        bit got = 0;
        stalled = 0;
        update_x = ax; update_y = ay; update_free = af; update_valid = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clock);
            if (update_ready) got = 1;
            else stalled = 1;
            tick();
        end
        update_valid = 1'b0;
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && written < n; i++) tick();
        if (written < n) check("write_timeout", written, n);
    endtask

    task automatic wait_dones(input int n, input int budget);
        for (int i = 0; i < budget && dones < n; i++) tick();
        if (dones < n) check("clear_timeout", dones, n);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic pulse_clear();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
    endtask

    initial begin
        bit st, any_stall;
        int w0, d0, c0, x0, a0, bad_gaps, base;

        // Reset state
        repeat (3) tick();
        check("reset_outputs", {update_ready, busy, clear_done, zero_cell, write_enable,
              cell_is_free, reset_counter, enable_counter, x, y}, 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", update_ready, 1);
        check("busy_after_reset", busy, 0);

        // Single update
        w0 = written;
        send(8'd5, 7'd3, 1'b0, st);
        wait_writes(w0 + 1, 20);
        check("single_latency", last_latency, 2);
        check("single_busy_after", busy, 0);

        // Burst with valid held high: FIFO fills, writes every 2 cycles
        w0 = written; base = wr_cyc.size(); any_stall = 0;
        for (int i = 0; i < 9; i++) begin
            send(XW'(20 + i), YW'(40 + 3 * i), 1'(i), st);
            if (st) any_stall = 1;
        end
        wait_writes(w0 + 9, 100);
        check("burst_ready_drop", any_stall, 1);
        bad_gaps = 0;
        for (int i = 1; i < 9; i++)
            if (wr_cyc[base + i] - wr_cyc[base + i - 1] != 2) bad_gaps++;
        check("burst_spacing", bad_gaps, 0);
        wait_idle(50);

        // Full-length clear from idle
        sweep_len = 32768; c0 = clears; d0 = dones; ready_viol = 0; xy_viol = 0;
        pulse_clear();
        wait_dones(d0 + 1, 40000);
        check("clear_init_pulses", clears - c0, 1);
        check("clear_run_cycles", clr_cycles, 32768);
        check("clear_done_gap", done_gap, 1);
        check("clear_ready_low", ready_viol, 0);
        check("clear_xy_zero", xy_viol, 0);
        check("clear_busy_after", busy, 0);

        // Three queued, clear during the first UPD_READ
        sweep_len = 64; w0 = written; x0 = discarded; d0 = dones;
        update_valid = 1'b1; update_x = 8'd10; update_y = 7'd20; update_free = 1'b1;
        tick();
        update_x = 8'd11; update_y = 7'd21; update_free = 1'b0;
        tick();
        clear_start = 1'b1; update_x = 8'd12; update_y = 7'd22;
        tick();
        clear_start = 1'b0; update_valid = 1'b0;
        wait_dones(d0 + 1, 300);
        check("midclear_written", written - w0, 1);
        check("midclear_discarded", discarded - x0, 2);
        check("midclear_run_cycles", clr_cycles, 64);

        // Reset 100 cycles into a clear, then a normal update
        tick();
        sweep_len = 32768;
        pulse_clear();
        repeat (100) tick();
        reset = 1'b1;
        tick();
        check("abort_outputs", {update_ready, busy, clear_done, zero_cell, write_enable,
              cell_is_free, reset_counter, enable_counter, x, y}, 0);
        reset = 1'b0;
        w0 = written;
        send(8'd77, 7'd99, 1'b1, st);
        wait_writes(w0 + 1, 20);
        check("abort_then_update_latency", last_latency, 2);

        // Randomized traffic with occasional clears
        tick();
        sweep_len = 16; a0 = accepted; w0 = written; x0 = discarded; c0 = clears; d0 = dones;
        ready_viol = 0; xy_viol = 0;
        for (int i = 0; i < 3000; i++) begin
            update_valid = 1'($urandom_range(0, 1));
            update_x     = XW'($urandom);
            update_y     = YW'($urandom);
            update_free  = 1'($urandom);
            clear_start  = ($urandom_range(0, 99) == 0);
            tick();
        end
        update_valid = 1'b0; clear_start = 1'b0;
        wait_idle(500);
        repeat (2) tick();
        check("rand_conservation", accepted - a0, (written - w0) + (discarded - x0));
        check("rand_queue_empty", expq.size(), 0);
        check("rand_clears_done", dones - d0, clears - c0);
        check("rand_ready_low", ready_viol, 0);
        check("rand_xy_zero", xy_viol, 0);

`ifdef OCC_CTRL_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        w0 = written;
        for (int i = 0; i < 10; i++) send(XW'(i), YW'(i), 1'b0, st);
        wait_writes(w0 + 10, 100);
        wait_idle(20);
        check("stats_count", update_count, 10);
        d0 = dones;
        pulse_clear();
        wait_dones(d0 + 1, 100);
        check("stats_cleared", update_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
